memory_bank: RTL and testbench

Parametrised single-port synchronous RAM for the 6502 system bus. Replaces the fixed vendor BRAM instance with an inferred array, a configurable read latency and a valid strobe. It also has an optional clear sequencer that zeroes the array after every reset before accepting CPU or loader traffic. It sits between the bus decoder and storage for zero page, stack and general RAM.

---
 rtl/mem_pkg.sv | 19 +
 rtl/memory_array.sv | 32 +++
 rtl/memory_bank.sv | 146 ++++++++++++++
 tb/tb_memory_bank.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory_bank slice.
//   state_t            : sequencer states (CLEAR while zeroing the array, READY afterwards)
//   RD_LATENCY_MIN/MAX : supported read latencies
//   rd_latency_legal() : elaboration-time legality check for RD_LATENCY
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    function automatic bit rd_latency_legal(input int lat);
        return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/memory_array.sv
// Inferred single-port synchronous RAM: one write port, one registered read
// port, no reset, so it maps onto block RAM.
//   clk      in  clock
//   we       in  write enable (writes wr_data to mem[addr])
//   re       in  read enable (captures mem[addr] into rd_data)
//   addr     in  word address
//   wr_data  in  write data
//   rd_data  out registered read data; holds when re=0
module memory_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_bank.sv
// RAM bank for the 6502 system bus: inferred array, optional clear-after-reset
// sequencer, read latency of 1 or 2 cycles and a rd_valid strobe.
//   clk      in  rising-edge clock
//   resetn   in  asynchronous active-low reset
//   req      in  access request, sampled only while ready=1
//   we       in  1 = write, 0 = read
//   addr     in  word address
//   wr_data  in  write data
//   rd_data  out read data, holds between reads, 0 after reset
//   rd_valid out one-cycle pulse marking new read data
//   ready    out 1 = accepting requests
//
// state | meaning
// CLEAR | writing CLEAR_VALUE to mem[clr_cnt], one location per cycle
// READY | serving requester traffic until the next reset
module memory_bank
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 12,
    parameter int                    RD_LATENCY     = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  ready
);

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $error("memory_bank: RD_LATENCY must be 1 or 2");
    end

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [ADDR_WIDTH-1:0]   clr_cnt_nxt;
    logic                    mem_we;
    logic                    mem_re;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_q;
    logic                    v1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = addr;
        mem_wdata   = wr_data;
        case (state)
            CLEAR: begin
                mem_we      = 1'b1;
                mem_addr    = clr_cnt;
                mem_wdata   = CLEAR_VALUE;
                clr_cnt_nxt = clr_cnt + 1'b1;
                // Leave on the edge that writes the last location; no wrap rewrite.
                if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                mem_we = req & we;
                mem_re = req & ~we;
            end
            default: state_nxt = READY;
        endcase
    end

    assign ready = (state == READY);

    memory_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .re      (mem_re),
        .addr    (mem_addr),
        .wr_data (mem_wdata),
        .rd_data (mem_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1 <= 1'b0;
        end else begin
            v1 <= mem_re;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  v2;
        logic [DATA_WIDTH-1:0] out_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                v2    <= 1'b0;
                out_q <= '0;
            end else begin
                v2 <= v1;
                if (v1) begin
                    out_q <= mem_q;
                end
            end
        end

        assign rd_valid = v2;
        assign rd_data  = out_q;
    end else begin : g_lat1
        // The RAM output register has no reset, so mask it to zero until the
        // first read after reset has delivered data.
        logic have_data;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                have_data <= 1'b0;
            end else if (v1) begin
                have_data <= 1'b1;
            end
        end

        assign rd_valid = v1;
        assign rd_data  = (have_data || v1) ? mem_q : '0;
    end

endmodule

// File: tb/tb_memory_bank.sv
// Scoreboard bench for memory_bank: two default-parameter instances (read
// latency 1 and 2) share stimulus, a third runs without the clear sequencer.
module tb_memory_bank;

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data1, rd_data2, rd_data3;
    logic        rd_valid1, rd_valid2, rd_valid3;
    logic        ready1, ready2, ready3;

    logic        resetn3;
    logic        req3;
    logic        we3;
    logic [11:0] addr3;
    logic [7:0]  wr_data3;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    exp_t e1, e2, e3;
    logic [7:0] last1 = 8'h00;
    logic [7:0] last2 = 8'h00;
    logic [7:0] last3 = 8'h00;
    logic [7:0] model  [0:4095];
    logic [7:0] model3 [0:4095];
    int          k;
    logic [11:0] ra;

    memory_bank #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .ready(ready1));

    memory_bank #(.RD_LATENCY(2)) dut2 (
        .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .ready(ready2));

    memory_bank #(.RD_LATENCY(1), .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'h3C)) dut3 (
        .clk(clk), .resetn(resetn3), .req(req3), .we(we3), .addr(addr3), .wr_data(wr_data3),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .ready(ready3));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm, input logic [7:0] d);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got rd_valid with data %h, required no pulse (cycle %0d)", nm, d, cyc);
    endtask

    // Monitors: compare whenever a rd_valid is presented, otherwise rd_data must hold.
    always @(negedge clk) begin
        if (rd_valid1) begin
            if (q1.size() == 0) unexpected("valid1", rd_data1);
            else begin
                e1 = q1.pop_front();
                check8("rd_data1", rd_data1, e1.d);
                check_int("rd_cycle1", cyc, e1.due);
                last1 = e1.d;
            end
        end else check8("hold1", rd_data1, last1);
    end

    always @(negedge clk) begin
        if (rd_valid2) begin
            if (q2.size() == 0) unexpected("valid2", rd_data2);
            else begin
                e2 = q2.pop_front();
                check8("rd_data2", rd_data2, e2.d);
                check_int("rd_cycle2", cyc, e2.due);
                last2 = e2.d;
            end
        end else check8("hold2", rd_data2, last2);
    end

    always @(negedge clk) begin
        if (rd_valid3) begin
            if (q3.size() == 0) unexpected("valid3", rd_data3);
            else begin
                e3 = q3.pop_front();
                check8("rd_data3", rd_data3, e3.d);
                check_int("rd_cycle3", cyc, e3.due);
                last3 = e3.d;
            end
        end else check8("hold3", rd_data3, last3);
    end

    // One bus cycle for dut1/dut2; assumes ready=1 and updates the model.
    task automatic issue(input logic r, input logic w, input logic [11:0] a, input logic [7:0] d);
        exp_t x;
        @(posedge clk);
        #1;
        req = r; we = w; addr = a; wr_data = d;
        if (r && w) model[a] = d;
        else if (r) begin
            x.d = model[a];
            x.due = cyc + 1; q1.push_back(x);
            x.due = cyc + 2; q2.push_back(x);
        end
    endtask

    task automatic issue3(input logic r, input logic w, input logic [11:0] a, input logic [7:0] d);
        exp_t x;
        @(posedge clk);
        #1;
        req3 = r; we3 = w; addr3 = a; wr_data3 = d;
        if (r && w) model3[a] = d;
        else if (r) begin
            x.d = model3[a];
            x.due = cyc + 1; q3.push_back(x);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0; req = 1'b0; we = 1'b0;
        q1.delete(); q2.delete();
        last1 = 8'h00; last2 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check8("ready1_in_reset", {7'b0, ready1}, 8'h00);
        check8("ready2_in_reset", {7'b0, ready2}, 8'h00);
    endtask

    // Release reset and count edges until ready; optionally poke requests mid-clear.
    task automatic clear_seq(input int inject_at);
        int edges;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        edges = 0;
        while (ready1 !== 1'b1 && edges < 5000) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == inject_at) begin
                req = 1'b1; we = 1'b1; addr = 12'h005; wr_data = 8'hFF;
            end
            if (edges == inject_at + 3) we = 1'b0;
            if (edges == inject_at + 6) req = 1'b0;
        end
        check_int("clear_len", edges, 4096);
        check8("ready2_after_clear", {7'b0, ready2}, 8'h01);
        for (int i = 0; i < 4096; i++) model[i] = 8'h00;
    endtask

    task automatic drain();
        repeat (4) issue(1'b0, 1'b0, 12'h000, 8'h00);
        check_int("drain_q1", q1.size(), 0);
        check_int("drain_q2", q2.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wr_data = '0;
        resetn3 = 1'b0; req3 = 1'b0; we3 = 1'b0; addr3 = '0; wr_data3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check8("ready1_reset", {7'b0, ready1}, 8'h00);
        check8("ready2_reset", {7'b0, ready2}, 8'h00);
        check8("ready3_reset", {7'b0, ready3}, 8'h01);
        resetn3 = 1'b1;

        // Power-up clear with ignored write/read attempts part way through.
        clear_seq(100);
        issue(1'b1, 1'b0, 12'h000, 8'h00);
        issue(1'b1, 1'b0, 12'h7FF, 8'h00);
        issue(1'b1, 1'b0, 12'hFFF, 8'h00);
        issue(1'b1, 1'b0, 12'h005, 8'h00);
        issue(1'b0, 1'b0, 12'h000, 8'h00);

        // Write then read next cycle; read then overwrite the same address.
        issue(1'b1, 1'b1, 12'h123, 8'hA5);
        issue(1'b1, 1'b0, 12'h123, 8'h00);
        issue(1'b1, 1'b0, 12'h124, 8'h00);
        issue(1'b1, 1'b1, 12'h124, 8'h77);
        issue(1'b1, 1'b0, 12'h124, 8'h00);

        // Streaming reads after writing data = addr.
        for (int i = 16; i < 32; i++) issue(1'b1, 1'b1, 12'(i), 8'(i));
        for (int i = 16; i < 32; i++) issue(1'b1, 1'b0, 12'(i), 8'h00);
        drain();

        // Random interleaved traffic, concentrated on a few addresses.
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) ra = 12'($urandom);
            else ra = 12'($urandom_range(0, 15));
            if (k < 2) issue(1'b0, 1'b0, ra, 8'h00);
            else if (k < 6) issue(1'b1, 1'b1, ra, 8'($urandom));
            else issue(1'b1, 1'b0, ra, 8'h00);
        end
        drain();

        // Reset part way through a clear (counter at 0x800), then a full clear.
        issue(1'b1, 1'b1, 12'h123, 8'h5A);
        do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2047) @(posedge clk);
        do_reset();
        clear_seq(-100);
        issue(1'b1, 1'b0, 12'h123, 8'h00);
        issue(1'b1, 1'b0, 12'h010, 8'h00);
        drain();

        // Reset with a read in flight: no rd_valid may follow.
        issue(1'b1, 1'b1, 12'h200, 8'hC3);
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; addr = 12'h200;
        do_reset();
        clear_seq(-100);
        issue(1'b1, 1'b0, 12'h200, 8'h00);
        drain();

        // Instance without clear sequencer: contents survive reset.
        issue3(1'b1, 1'b1, 12'h001, 8'h11);
        issue3(1'b1, 1'b1, 12'h800, 8'h22);
        issue3(1'b1, 1'b1, 12'hFFF, 8'h33);
        issue3(1'b1, 1'b0, 12'h001, 8'h00);
        issue3(1'b1, 1'b0, 12'h800, 8'h00);
        issue3(1'b1, 1'b0, 12'hFFF, 8'h00);
        issue3(1'b0, 1'b0, 12'h000, 8'h00);
        issue3(1'b0, 1'b0, 12'h000, 8'h00);
        @(posedge clk);
        #1;
        resetn3 = 1'b0;
        q3.delete();
        last3 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check8("ready3_in_reset", {7'b0, ready3}, 8'h01);
        resetn3 = 1'b1;
        @(posedge clk);
        #1;
        check8("ready3_after_reset", {7'b0, ready3}, 8'h01);
        issue3(1'b1, 1'b0, 12'hFFF, 8'h00);
        issue3(1'b1, 1'b0, 12'h001, 8'h00);
        issue3(1'b1, 1'b0, 12'h800, 8'h00);
        repeat (4) issue3(1'b0, 1'b0, 12'h000, 8'h00);
        check_int("drain_q3", q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
